// File: rtl/div_issue_stage.sv
// Issue/retire stage around a combinational divider: operand FIFO in front,
// registered quotient with divide-by-zero flag behind, valid/ready on both sides.
module div_issue_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] DivA,
  output logic [WIDTH-1:0] DivB,
  input  logic [WIDTH-1:0] DivQ,
  output logic [WIDTH-1:0] OutQ,
  output logic             OutDz,
  output logic             OutValid,
  input  logic             OutReady
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [WIDTH-1:0] mem_b_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] out_q_q, out_q_d;
  logic             out_dz_q, out_dz_d;
  logic             out_valid_q, out_valid_d;

  logic             not_empty;
  logic             free;
  logic             push;
  logic             pop;
  logic             div_by_zero;

  assign not_empty   = (count_q != '0);
  assign InReady     = (count_q != FULL);
  assign free        = !out_valid_q || OutReady;
  assign push        = InValid && InReady;
  assign pop         = not_empty && free;

  assign DivA        = not_empty ? mem_a_q[rd_ptr_q] : '0;
  assign DivB        = not_empty ? mem_b_q[rd_ptr_q] : '0;
  assign div_by_zero = (DivB == '0);

  assign OutQ        = out_q_q;
  assign OutDz       = out_dz_q;
  assign OutValid    = out_valid_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_q_d     = out_q_q;
    out_dz_d    = out_dz_q;
    out_valid_d = out_valid_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);

    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      out_q_d     = div_by_zero ? '1 : DivQ;
      out_dz_d    = div_by_zero;
      out_valid_d = 1'b1;
    end else if (free) begin
      out_valid_d = 1'b0;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Operand storage carries no reset; the count alone decides what is live.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= InA;
      mem_b_q[wr_ptr_q] <= InB;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_q_q     <= '0;
      out_dz_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_q_q     <= out_q_d;
      out_dz_q    <= out_dz_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_div_issue_stage.sv
// Directed bench for div_issue_stage; a behavioural divider closes the DivA/DivB -> DivQ loop.
module tb_div_issue_stage;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [15:0] InA, InB;
  logic        InValid;
  logic        InReady;
  logic [15:0] DivA, DivB, DivQ;
  logic [15:0] OutQ;
  logic        OutDz;
  logic        OutValid;
  logic        OutReady;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  // Garbage on B=0 so the stage's own forcing to all-ones is what gets observed.
  assign DivQ = (DivB == 16'd0) ? 16'h1234 : DivA / DivB;

  div_issue_stage #(.WIDTH(16), .DEPTH(2)) dut (
    .Clk(Clk), .Rst(Rst),
    .InA(InA), .InB(InB), .InValid(InValid), .InReady(InReady),
    .DivA(DivA), .DivB(DivB), .DivQ(DivQ),
    .OutQ(OutQ), .OutDz(OutDz), .OutValid(OutValid), .OutReady(OutReady)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b);
    InValid = v;
    InA     = a;
    InB     = b;
  endtask

  initial begin
    Rst = 1'b0; OutReady = 1'b1;
    drive(1'b0, 16'd0, 16'd0);
    step(); step();
    Rst = 1'b1;
    chk("rst_valid", {15'd0, OutValid}, 16'd0);
    chk("rst_q", OutQ, 16'd0);
    chk("rst_dz", {15'd0, OutDz}, 16'd0);
    chk("rst_inready", {15'd0, InReady}, 16'd1);
    chk("rst_diva", DivA, 16'd0);
    chk("rst_divb", DivB, 16'd0);

    // single op, 2-edge latency
    drive(1'b1, 16'd64, 16'd8);
    step();
    drive(1'b0, 16'd0, 16'd0);
    chk("lat_head_a", DivA, 16'd64);
    chk("lat_head_b", DivB, 16'd8);
    chk("lat_not_yet", {15'd0, OutValid}, 16'd0);
    step();
    chk("lat_valid", {15'd0, OutValid}, 16'd1);
    chk("lat_q", OutQ, 16'd8);
    chk("lat_dz", {15'd0, OutDz}, 16'd0);
    step();
    chk("lat_drop", {15'd0, OutValid}, 16'd0);

    // back-to-back at full throughput, plus max dividend
    drive(1'b1, 16'd64, 16'd8);   step();
    chk("b2b_rdy0", {15'd0, InReady}, 16'd1);
    drive(1'b1, 16'd65, 16'd8);   step();
    chk("b2b_q0", OutQ, 16'd8);
    chk("b2b_v0", {15'd0, OutValid}, 16'd1);
    chk("b2b_rdy1", {15'd0, InReady}, 16'd1);
    drive(1'b1, 16'd256, 16'd257); step();
    chk("b2b_q1", OutQ, 16'd8);
    chk("b2b_rdy2", {15'd0, InReady}, 16'd1);
    drive(1'b1, 16'hFFFF, 16'd1); step();
    chk("b2b_q2", OutQ, 16'd0);
    chk("b2b_v2", {15'd0, OutValid}, 16'd1);
    drive(1'b0, 16'd0, 16'd0);    step();
    chk("b2b_qmax", OutQ, 16'hFFFF);
    chk("b2b_dzmax", {15'd0, OutDz}, 16'd0);
    step();
    chk("b2b_drop", {15'd0, OutValid}, 16'd0);

    // divide by zero followed by a normal pair
    drive(1'b1, 16'd1, 16'd0);  step();
    drive(1'b1, 16'd64, 16'd8); step();
    chk("dz_q", OutQ, 16'hFFFF);
    chk("dz_flag", {15'd0, OutDz}, 16'd1);
    drive(1'b0, 16'd0, 16'd0);  step();
    chk("dz_next_q", OutQ, 16'd8);
    chk("dz_next_flag", {15'd0, OutDz}, 16'd0);
    step();
    chk("dz_drop", {15'd0, OutValid}, 16'd0);

    // backpressure: capacity DEPTH+1, then drain in order
    OutReady = 1'b0;
    drive(1'b1, 16'd10, 16'd2); step();
    drive(1'b1, 16'd20, 16'd2); step();
    drive(1'b1, 16'd30, 16'd2); step();
    chk("bp_full", {15'd0, InReady}, 16'd0);
    drive(1'b1, 16'd40, 16'd2);
    for (int unsigned i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_rdy", {15'd0, InReady}, 16'd0);
      chk("bp_hold_v", {15'd0, OutValid}, 16'd1);
      chk("bp_hold_q", OutQ, 16'd5);
      chk("bp_hold_dz", {15'd0, OutDz}, 16'd0);
      chk("bp_hold_diva", DivA, 16'd20);
      chk("bp_hold_divb", DivB, 16'd2);
    end
    OutReady = 1'b1;
    step();
    chk("bp_q10", OutQ, 16'd10);
    chk("bp_rdy_again", {15'd0, InReady}, 16'd1);
    step();
    drive(1'b0, 16'd0, 16'd0);
    chk("bp_q15", OutQ, 16'd15);
    step();
    chk("bp_q20", OutQ, 16'd20);
    chk("bp_v20", {15'd0, OutValid}, 16'd1);
    step();
    chk("bp_drop", {15'd0, OutValid}, 16'd0);

    // reset with two buffered pairs and a pending result
    OutReady = 1'b0;
    drive(1'b1, 16'd100, 16'd10); step();
    drive(1'b1, 16'd200, 16'd10); step();
    drive(1'b1, 16'd300, 16'd10); step();
    chk("mr_pending_v", {15'd0, OutValid}, 16'd1);
    chk("mr_pending_q", OutQ, 16'd10);
    chk("mr_full", {15'd0, InReady}, 16'd0);
    drive(1'b0, 16'd0, 16'd0);
    Rst = 1'b0; step();
    Rst = 1'b1; OutReady = 1'b1;
    chk("mr_valid", {15'd0, OutValid}, 16'd0);
    chk("mr_q", OutQ, 16'd0);
    chk("mr_dz", {15'd0, OutDz}, 16'd0);
    chk("mr_inready", {15'd0, InReady}, 16'd1);
    chk("mr_diva", DivA, 16'd0);
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      chk("mr_no_stale", {15'd0, OutValid}, 16'd0);
    end
    drive(1'b1, 16'd7, 16'd7); step();
    drive(1'b0, 16'd0, 16'd0); step();
    chk("mr_post_q", OutQ, 16'd1);
    chk("mr_post_v", {15'd0, OutValid}, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_issue_stage.md
Name: div_issue_stage

Overview:
Sequential front/back stage wrapped around the combinational DIV datapath component (WIDTH-parameterised, A/B in, Q out). It accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO. It presents the FIFO head to DIV and captures DIV's quotient into a registered result port with its own valid/ready handshake. Divide-by-zero is detected and flagged here, so DIV's undefined output for B=0 never propagates.

Parameters:
WIDTH, 16, operand/quotient width; must equal the WIDTH of the attached DIV instance
DEPTH, 2, operand FIFO entries; power of two, >= 2

Ports:
Clk  input  1  clock; all state updates on rising edge
Rst  input  1  synchronous, active-low reset
InA  input  WIDTH  dividend
InB  input  WIDTH  divisor
InValid  input  1  operand pair valid
InReady  output  1  stage can accept a pair this cycle
DivA  output  WIDTH  dividend driven to DIV A
DivB  output  WIDTH  divisor driven to DIV B
DivQ  input  WIDTH  quotient returned from DIV Q (combinational function of DivA/DivB)
OutQ  output  WIDTH  registered quotient
OutDz  output  1  registered divide-by-zero flag for OutQ
OutValid  output  1  OutQ/OutDz valid
OutReady  input  1  consumer accepts result

Behaviour:
- Reset (Rst=0 at a rising edge): FIFO read/write pointers and count cleared; OutValid=0, OutQ=0, OutDz=0; InReady=1 from the following cycle. FIFO storage is not reset.
- Reset mid-operation: all buffered operands and any pending result are discarded; no result is emitted for them.
- Push: when InValid && InReady, {InA,InB} is written at the write pointer; the pointer wraps modulo DEPTH.
- InReady = (count != DEPTH). It is a pure function of registered count, with no combinational path from OutReady or InValid.
- Head presentation: when count != 0, DivA/DivB = entry at the read pointer. When empty, DivA=0 and DivB=0.
- Result slot free: free = !OutValid || OutReady.
- Pop/capture: when count != 0 && free, at the edge:
  - OutQ <= (DivB==0) ? all-ones : DivQ
  - OutDz <= (DivB==0)
  - OutValid <= 1
  - the read pointer advances and wraps.
- If free && count==0: OutValid <= 0. OutQ/OutDz hold their values.
- If !free: OutQ, OutDz and OutValid hold. The FIFO head is not consumed.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance. With count==DEPTH, push cannot occur because InReady=0, even if a pop happens that cycle.
- Latency: pair accepted at edge n, FIFO empty and slot free → OutValid=1 with its result in the cycle after edge n+1 (2 edges). Sustained throughput is 1 result/cycle with OutReady held high.
- Ordering: results are emitted strictly in acceptance order.
- Width rules: quotient is unsigned WIDTH bits, taken directly from DIV. The divide-by-zero result is forced to {WIDTH{1'b1}}.
- Capacity under backpressure: DEPTH pairs in FIFO plus 1 in the result register.

Test Plan:
- Reset, then push A=64, B=8 with OutReady=1 → OutValid high 2 edges later, OutQ=16'd8, OutDz=0; OutValid drops the next cycle.
- Back-to-back pushes (64,8), (65,8), (256,257) on consecutive cycles, OutReady=1 → OutQ=8, 8, 0 on three consecutive cycles, OutDz=0, InReady stays 1.
- Push A=1, B=0 → OutQ=16'hFFFF, OutDz=1; a following pair (64,8) → OutQ=8, OutDz=0.
- OutReady=0, push (10,2), (20,2), (30,2), (40,2) → first three accepted, InReady=0 while the fourth is held. Raise OutReady → results 5, 10, 15 emitted in order; the fourth is accepted once InReady=1, then result 20.
- Hold OutValid=1 with OutReady=0 for 5 cycles → OutQ/OutDz stable, DivA/DivB show the next head unchanged.
- Assert Rst=0 for one cycle with 2 pairs buffered and OutValid=1 → next cycle OutValid=0, OutQ=0, InReady=1; no stale results appear afterward.
